timer_scheduler: RTL

- Shares one tick source among N_REQ requesters by time-division. The tick source is the `done` pulse of the existing Timer prescaler.
- Each requester asks for a delay of D ticks. The scheduler grants one requester at a time using round-robin, counts D ticks for it, then pulses that requester's expire line.
- Sits between the Timer prescaler and client blocks such as debouncers, LED blinkers and timeouts, so they no longer each need a private Timer.

---
 rtl/timer_scheduler.sv | 103 ++++++++++
 1 files changed

// File: rtl/timer_scheduler.sv
// timer_scheduler: shares one prescaler tick among N_REQ requesters.
// One requester at a time owns the tick counter (round-robin); after
// counting its requested number of ticks it receives a one-cycle expire.
//
// state | meaning
// IDLE  | no owner; arbitrate among pending requests
// RUN   | active_id owns the counter; remaining decrements on tick
// DONE  | single cycle; expire pulses for active_id
module timer_scheduler #(
  parameter int N_REQ = 4,
  parameter int DW    = 8,
  parameter int ID_W  = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                tick,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] delay_i,
  output logic [N_REQ-1:0]    grant,
  output logic [N_REQ-1:0]    expire,
  output logic                busy,
  output logic [ID_W-1:0]     active_id,
  output logic [DW-1:0]       remaining
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  state_t          state;
  logic [ID_W-1:0] last;
  logic [ID_W-1:0] win;
  logic            found;
  logic [ID_W:0]   cand;

  // Round-robin winner: first pending request after the last winner, wrapping
  always_comb begin
    win   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = {1'b0, last} + (ID_W+1)'(i);
      if (cand >= (ID_W+1)'(N_REQ)) cand = cand - (ID_W+1)'(N_REQ);
      if (!found && req[cand[ID_W-1:0]]) begin
        win   = cand[ID_W-1:0];
        found = 1'b1;
      end
    end
  end

  // Scheduler FSM; every output is a register so clients see clean levels
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      grant     <= '0;
      expire    <= '0;
      busy      <= 1'b0;
      active_id <= '0;
      remaining <= '0;
      last      <= ID_W'(N_REQ-1);
    end else begin
      case (state)
        IDLE: begin
          expire <= '0;
          if (found) begin
            state     <= RUN;
            grant     <= ONE << win;
            active_id <= win;
            remaining <= delay_i[win*DW +: DW];
            last      <= win;
            busy      <= 1'b1;
          end
        end
        RUN: begin
          if (!req[active_id]) begin
            // requester withdrew: release the counter without an expire
            state <= IDLE;
            grant <= '0;
            busy  <= 1'b0;
          end else if (remaining == '0) begin
            state  <= DONE;
            grant  <= '0;
            expire <= ONE << active_id;
          end else if (tick) begin
            remaining <= remaining - 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          expire <= '0;
          busy   <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          grant  <= '0;
          expire <= '0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule
